// File: rtl/reg_alu_ctrl_pkg.sv
// Shared types for reg_alu_ctrl: command and state encodings plus instruction field positions.
package reg_alu_ctrl_pkg;

    localparam int unsigned InstrW  = 16;
    localparam int unsigned CmdMsb  = 15;
    localparam int unsigned CmdLsb  = 13;
    localparam int unsigned DstMsb  = 12;
    localparam int unsigned DstLsb  = 10;
    localparam int unsigned SrcAMsb = 9;
    localparam int unsigned SrcALsb = 7;
    localparam int unsigned SrcBMsb = 6;
    localparam int unsigned SrcBLsb = 4;
    localparam int unsigned OpMsb   = 1;
    localparam int unsigned OpLsb   = 0;

    typedef enum logic [2:0] {
        CmdNop = 3'b000,
        CmdLdi = 3'b001,
        CmdAlu = 3'b010,
        CmdRd  = 3'b011,
        CmdAcc = 3'b100,
        CmdClc = 3'b101
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StOut  = 2'b10
    } state_e;

endpackage

// File: rtl/reg_alu_ctrl_decode.sv
// Combinational instruction splitter and command classifier.
// CLC is only recognised when REG_ALU_CTRL_CARRY_EN is defined; otherwise it decodes as NOP.
module reg_alu_ctrl_decode
    import reg_alu_ctrl_pkg::*;
(
    input  logic [InstrW-1:0] instr_i,
    output cmd_e              cmd_o,
    output logic [2:0]        dst_o,
    output logic [2:0]        src_a_o,
    output logic [2:0]        src_b_o,
    output logic [1:0]        op_o
);

    // instr[3:2] carries no meaning.
    logic unused_bits;
    assign unused_bits = ^instr_i[3:2];

    assign dst_o   = instr_i[DstMsb:DstLsb];
    assign src_a_o = instr_i[SrcAMsb:SrcALsb];
    assign src_b_o = instr_i[SrcBMsb:SrcBLsb];
    assign op_o    = instr_i[OpMsb:OpLsb];

    always_comb begin
        cmd_o = CmdNop;
        case (instr_i[CmdMsb:CmdLsb])
            3'b001:  cmd_o = CmdLdi;
            3'b010:  cmd_o = CmdAlu;
            3'b011:  cmd_o = CmdRd;
            3'b100:  cmd_o = CmdAcc;
`ifdef REG_ALU_CTRL_CARRY_EN
            3'b101:  cmd_o = CmdClc;
`endif
            default: cmd_o = CmdNop;
        endcase
    end

endmodule

// File: rtl/reg_alu_ctrl.sv
// Sequencer driving a register-file/ALU datapath: LDI, ALU, RD, ACC (and CLC).
// Optional sticky carry flag enabled by defining REG_ALU_CTRL_CARRY_EN.
module reg_alu_ctrl
    import reg_alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] imm,
    output logic        rf_wr,
    output logic [2:0]  rf_wr_addr,
    output logic [2:0]  rf_rd_addr_a,
    output logic [2:0]  rf_rd_addr_b,
    output logic        rf_sel_ext,
    output logic [1:0]  rf_op,
    output logic [15:0] rf_d_in,
    input  logic [15:0] rf_d_out_a,
    input  logic        rf_cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        carry_flag
);

    cmd_e       dec_cmd;
    logic [2:0] dec_dst, dec_src_a, dec_src_b;
    logic [1:0] dec_op;

    reg_alu_ctrl_decode u_decode (
        .instr_i (instr),
        .cmd_o   (dec_cmd),
        .dst_o   (dec_dst),
        .src_a_o (dec_src_a),
        .src_b_o (dec_src_b),
        .op_o    (dec_op)
    );

    state_e      state_d, state_q;
    cmd_e        cmd_d, cmd_q;
    logic [3:0]  cnt_d, cnt_q;
    logic        rf_wr_d, rf_wr_q;
    logic [2:0]  rf_wr_addr_d, rf_wr_addr_q;
    logic [2:0]  rf_rd_addr_a_d, rf_rd_addr_a_q;
    logic [2:0]  rf_rd_addr_b_d, rf_rd_addr_b_q;
    logic        rf_sel_ext_d, rf_sel_ext_q;
    logic [1:0]  rf_op_d, rf_op_q;
    logic [15:0] rf_d_in_d, rf_d_in_q;
    logic        res_valid_d, res_valid_q;
    logic [15:0] res_data_d, res_data_q;

    // Datapath controls are registered, so they are computed one cycle ahead of use.
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        cnt_d          = cnt_q;
        rf_wr_d        = 1'b0;
        rf_wr_addr_d   = rf_wr_addr_q;
        rf_rd_addr_a_d = rf_rd_addr_a_q;
        rf_rd_addr_b_d = rf_rd_addr_b_q;
        rf_sel_ext_d   = rf_sel_ext_q;
        rf_op_d        = rf_op_q;
        rf_d_in_d      = rf_d_in_q;
        res_valid_d    = res_valid_q;
        res_data_d     = res_data_q;

        unique case (state_q)
            StIdle: begin
                if (instr_valid && (dec_cmd != CmdNop)) begin
                    cmd_d     = dec_cmd;
                    rf_d_in_d = imm;
                    state_d   = StExec;
                    case (dec_cmd)
                        CmdLdi: begin
                            rf_wr_d      = 1'b1;
                            rf_wr_addr_d = dec_dst;
                            rf_sel_ext_d = 1'b1;
                        end
                        CmdAlu: begin
                            rf_wr_d        = 1'b1;
                            rf_wr_addr_d   = dec_dst;
                            rf_rd_addr_a_d = dec_src_a;
                            rf_rd_addr_b_d = dec_src_b;
                            rf_op_d        = dec_op;
                            rf_sel_ext_d   = 1'b0;
                        end
                        CmdRd: begin
                            rf_rd_addr_a_d = dec_src_a;
                        end
                        CmdAcc: begin
                            cnt_d          = imm[3:0];
                            rf_wr_d        = (imm[3:0] != 4'd0);
                            rf_wr_addr_d   = dec_dst;
                            rf_rd_addr_a_d = dec_dst;
                            rf_rd_addr_b_d = dec_src_b;
                            rf_op_d        = dec_op;
                            rf_sel_ext_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            StExec: begin
                state_d = StIdle;
                case (cmd_q)
                    CmdRd: begin
                        res_data_d  = rf_d_out_a;
                        res_valid_d = 1'b1;
                        state_d     = StOut;
                    end
                    CmdAcc: begin
                        // Counter holds writes still owed including the current one.
                        if (cnt_q > 4'd1) begin
                            cnt_d   = cnt_q - 4'd1;
                            rf_wr_d = 1'b1;
                            state_d = StExec;
                        end else begin
                            cnt_d = 4'd0;
                        end
                    end
                    default: ;
                endcase
            end
            StOut: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cmd_q          <= CmdNop;
            cnt_q          <= 4'd0;
            rf_wr_q        <= 1'b0;
            rf_wr_addr_q   <= 3'd0;
            rf_rd_addr_a_q <= 3'd0;
            rf_rd_addr_b_q <= 3'd0;
            rf_sel_ext_q   <= 1'b0;
            rf_op_q        <= 2'd0;
            rf_d_in_q      <= 16'd0;
            res_valid_q    <= 1'b0;
            res_data_q     <= 16'd0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            cnt_q          <= cnt_d;
            rf_wr_q        <= rf_wr_d;
            rf_wr_addr_q   <= rf_wr_addr_d;
            rf_rd_addr_a_q <= rf_rd_addr_a_d;
            rf_rd_addr_b_q <= rf_rd_addr_b_d;
            rf_sel_ext_q   <= rf_sel_ext_d;
            rf_op_q        <= rf_op_d;
            rf_d_in_q      <= rf_d_in_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
        end
    end

`ifdef REG_ALU_CTRL_CARRY_EN
    logic carry_d, carry_q;

    // A write with sel_ext=0 is always an ALU or ACC write.
    always_comb begin
        carry_d = carry_q;
        if (state_q == StExec) begin
            if (cmd_q == CmdClc) begin
                carry_d = 1'b0;
            end else if (rf_wr_q && !rf_sel_ext_q && rf_cout) begin
                carry_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_flag = carry_q;
`else
    logic unused_cout;
    assign unused_cout = rf_cout;
    assign carry_flag  = 1'b0;
`endif

    assign instr_ready  = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign rf_wr        = rf_wr_q;
    assign rf_wr_addr   = rf_wr_addr_q;
    assign rf_rd_addr_a = rf_rd_addr_a_q;
    assign rf_rd_addr_b = rf_rd_addr_b_q;
    assign rf_sel_ext   = rf_sel_ext_q;
    assign rf_op        = rf_op_q;
    assign rf_d_in      = rf_d_in_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;

endmodule
